scr1_pipe_mprf_np: RTL and testbench

Parametrised N-read/M-write multi-port register file for the SCR1 pipeline and its planned dual-issue variant.
- Generalises the 2R/1W register file in three ways: configurable read and write port counts, selectable async or registered read with write-first bypass, and selectable depth.
- Adds a hardware clear sequencer that zeroes x1..x(DEPTH-1) after reset or on request, so storage can stay non-resettable (RAM friendly).
- Sits between EXU/decode and writeback. x0 reads as 0.

---
 rtl/scr1_pipe_mprf_np_pkg.sv | 39 +++
 rtl/scr1_pipe_mprf_np_if.sv | 45 ++++
 rtl/scr1_pipe_mprf_np_rdport.sv | 94 +++++++++
 rtl/scr1_pipe_mprf_np.sv | 115 +++++++++++
 tb/tb_scr1_pipe_mprf_np.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scr1_pipe_mprf_np_pkg.sv
// Shared types and helpers for the N-read/M-write register file.
// Optional feature macro: SCR1_MPRF_PARITY_EN.
package scr1_mprf_np_pkg;

    localparam int unsigned MPRF_MAX_NWR = 2;
    localparam int unsigned MPRF_MAX_AW  = 8;

    typedef enum logic {
        SCR1_MPRF_FSM_CLR,
        SCR1_MPRF_FSM_RDY
    } type_scr1_mprf_np_fsm_e;

    typedef struct packed {
        logic hit;
        logic port;
    } type_scr1_mprf_np_wres_s;

    function automatic int unsigned mprf_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Later ports override earlier ones, so the highest matching index wins.
    function automatic type_scr1_mprf_np_wres_s mprf_wr_resolve(
        input logic [MPRF_MAX_NWR-1:0]                  we,
        input logic [MPRF_MAX_NWR-1:0][MPRF_MAX_AW-1:0] waddr,
        input logic [MPRF_MAX_AW-1:0]                   addr
    );
        type_scr1_mprf_np_wres_s res;
        res = '0;
        for (int unsigned j = 0; j < MPRF_MAX_NWR; j++) begin
            if (we[j] && (waddr[j] == addr)) begin
                res.hit  = 1'b1;
                res.port = 1'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/scr1_pipe_mprf_np_if.sv
// EXU <-> register file bus bundle (read, write and clear signals).
// Optional feature macro: SCR1_MPRF_PARITY_EN adds parity error/flip signals.
interface scr1_pipe_mprf_np_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
);
    import scr1_mprf_np_pkg::*;
    localparam int unsigned AW = mprf_aw(DEPTH);

    logic [NRD-1:0][AW-1:0]   exu2mprf_rs_addr_i;
    logic [NRD-1:0][XLEN-1:0] mprf2exu_rs_data_o;
    logic [NWR-1:0]           exu2mprf_w_req_i;
    logic [NWR-1:0][AW-1:0]   exu2mprf_rd_addr_i;
    logic [NWR-1:0][XLEN-1:0] exu2mprf_rd_data_i;
    logic                     exu2mprf_clr_req_i;
    logic                     mprf2exu_busy_o;
`ifdef SCR1_MPRF_PARITY_EN
    logic [NRD-1:0]           mprf2exu_par_err_o;
    logic [NWR-1:0]           tb_par_flip_i;

    modport master (
        output exu2mprf_rs_addr_i, exu2mprf_w_req_i, exu2mprf_rd_addr_i,
               exu2mprf_rd_data_i, exu2mprf_clr_req_i, tb_par_flip_i,
        input  mprf2exu_rs_data_o, mprf2exu_busy_o, mprf2exu_par_err_o
    );
    modport slave (
        input  exu2mprf_rs_addr_i, exu2mprf_w_req_i, exu2mprf_rd_addr_i,
               exu2mprf_rd_data_i, exu2mprf_clr_req_i, tb_par_flip_i,
        output mprf2exu_rs_data_o, mprf2exu_busy_o, mprf2exu_par_err_o
    );
`else
    modport master (
        output exu2mprf_rs_addr_i, exu2mprf_w_req_i, exu2mprf_rd_addr_i,
               exu2mprf_rd_data_i, exu2mprf_clr_req_i,
        input  mprf2exu_rs_data_o, mprf2exu_busy_o
    );
    modport slave (
        input  exu2mprf_rs_addr_i, exu2mprf_w_req_i, exu2mprf_rd_addr_i,
               exu2mprf_rd_data_i, exu2mprf_clr_req_i,
        output mprf2exu_rs_data_o, mprf2exu_busy_o
    );
`endif
endinterface

// File: rtl/scr1_pipe_mprf_np_rdport.sv
// One register-file read port: zero forcing, optional registered stage with write-first bypass.
// Optional feature macro: SCR1_MPRF_PARITY_EN adds the per-port parity error flag.
module scr1_mprf_np_rdport
    import scr1_mprf_np_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NWR      = 1,
    parameter int unsigned READ_REG = 0,
    parameter int unsigned AW       = mprf_aw(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     busy,
    input  logic [DEPTH-1:0][XLEN-1:0] mem,
`ifdef SCR1_MPRF_PARITY_EN
    input  logic [DEPTH-1:0]         par,
    output logic                     par_err,
`endif
    input  logic [NWR-1:0]           we_eff,
    input  logic [NWR-1:0][AW-1:0]   waddr,
    input  logic [NWR-1:0][XLEN-1:0] wdata,
    input  logic [AW-1:0]            addr,
    output logic [XLEN-1:0]          data
);
    logic                                   zero_now;
    logic [MPRF_MAX_NWR-1:0]                we_ext;
    logic [MPRF_MAX_NWR-1:0][MPRF_MAX_AW-1:0] waddr_ext;
    type_scr1_mprf_np_wres_s                wres;
    logic [XLEN-1:0]                        byp_data;
    logic                                   zero_q;
    logic                                   hit_q;
    logic [XLEN-1:0]                        rd_q;
    logic [XLEN-1:0]                        byp_q;

    assign zero_now = busy || (addr == '0);

    always_comb begin
        we_ext    = '0;
        waddr_ext = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            we_ext[j]    = we_eff[j];
            waddr_ext[j] = MPRF_MAX_AW'(waddr[j]);
        end
    end

    assign wres = mprf_wr_resolve(we_ext, waddr_ext, MPRF_MAX_AW'(addr));

    always_comb begin
        byp_data = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wres.port == 1'(j)) byp_data = wdata[j];
        end
    end

    // rd_q captures the pre-write array value; a same-cycle write reaches the output via byp_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            hit_q  <= 1'b0;
            rd_q   <= '0;
            byp_q  <= '0;
        end else begin
            zero_q <= zero_now;
            hit_q  <= wres.hit;
            rd_q   <= mem[addr];
            byp_q  <= byp_data;
        end
    end

    always_comb begin
        data = '0;
        if (READ_REG != 0) begin
            if (!zero_q) data = hit_q ? byp_q : rd_q;
        end else if (!zero_now) begin
            data = mem[addr];
        end
    end

`ifdef SCR1_MPRF_PARITY_EN
    logic par_bad_now;
    logic err_q;

    assign par_bad_now = !zero_now && ((^mem[addr]) != par[addr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= par_bad_now;
    end

    assign par_err = (READ_REG != 0) ? (err_q && !hit_q) : par_bad_now;
`endif

endmodule

// File: rtl/scr1_pipe_mprf_np.sv
// Parametrised N-read/M-write register file with hardware clear sweep of x1..x(DEPTH-1).
// Optional feature macro: SCR1_MPRF_PARITY_EN (per-entry even parity and read-side check).
module scr1_pipe_mprf_np
    import scr1_mprf_np_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned READ_REG = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    scr1_pipe_mprf_np_if.slave  mprf_bus
);
    localparam int unsigned   AW       = mprf_aw(DEPTH);
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

    type_scr1_mprf_np_fsm_e     state;
    logic [AW-1:0]              clr_cnt;
    logic                       busy;
    logic [NWR-1:0]             we_eff;
    logic [DEPTH-1:0][XLEN-1:0] mem;
    logic [NRD-1:0][XLEN-1:0]   rd_data;
`ifdef SCR1_MPRF_PARITY_EN
    logic [DEPTH-1:0]           par;
    logic [NRD-1:0]             rd_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCR1_MPRF_FSM_CLR;
            clr_cnt <= AW'(1);
            busy    <= 1'b1;
        end else begin
            case (state)
                SCR1_MPRF_FSM_CLR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state <= SCR1_MPRF_FSM_RDY;
                        busy  <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                SCR1_MPRF_FSM_RDY: begin
                    if (mprf_bus.exu2mprf_clr_req_i) begin
                        state   <= SCR1_MPRF_FSM_CLR;
                        clr_cnt <= AW'(1);
                        busy    <= 1'b1;
                    end
                end
                default: state <= SCR1_MPRF_FSM_CLR;
            endcase
        end
    end

    always_comb begin
        we_eff = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            we_eff[j] = mprf_bus.exu2mprf_w_req_i[j]
                     && (mprf_bus.exu2mprf_rd_addr_i[j] != '0)
                     && (state == SCR1_MPRF_FSM_RDY);
        end
    end

    // Storage is intentionally unreset; the sweep provides the defined contents.
    always_ff @(posedge clk) begin
        if (state == SCR1_MPRF_FSM_CLR) begin
            mem[clr_cnt] <= '0;
`ifdef SCR1_MPRF_PARITY_EN
            par[clr_cnt] <= 1'b0;
`endif
        end
        for (int unsigned j = 0; j < NWR; j++) begin
            if (we_eff[j]) begin
                mem[mprf_bus.exu2mprf_rd_addr_i[j]] <= mprf_bus.exu2mprf_rd_data_i[j];
`ifdef SCR1_MPRF_PARITY_EN
                par[mprf_bus.exu2mprf_rd_addr_i[j]] <= (^mprf_bus.exu2mprf_rd_data_i[j])
                                                     ^ mprf_bus.tb_par_flip_i[j];
`endif
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        scr1_mprf_np_rdport #(
            .XLEN     (XLEN),
            .DEPTH    (DEPTH),
            .NWR      (NWR),
            .READ_REG (READ_REG),
            .AW       (AW)
        ) u_rdport (
            .clk     (clk),
            .rst_n   (rst_n),
            .busy    (busy),
            .mem     (mem),
`ifdef SCR1_MPRF_PARITY_EN
            .par     (par),
            .par_err (rd_err[i]),
`endif
            .we_eff  (we_eff),
            .waddr   (mprf_bus.exu2mprf_rd_addr_i),
            .wdata   (mprf_bus.exu2mprf_rd_data_i),
            .addr    (mprf_bus.exu2mprf_rs_addr_i[i]),
            .data    (rd_data[i])
        );
    end

    assign mprf_bus.mprf2exu_rs_data_o = rd_data;
    assign mprf_bus.mprf2exu_busy_o    = busy;
`ifdef SCR1_MPRF_PARITY_EN
    assign mprf_bus.mprf2exu_par_err_o = rd_err;
`endif

endmodule

// File: tb/tb_scr1_pipe_mprf_np.sv
// Bench for scr1_pipe_mprf_np: async 2R/1W instance and registered 2R/2W instance vs array models.
// Parity scenarios compile in when SCR1_MPRF_PARITY_EN is defined.
module tb_scr1_pipe_mprf_np;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] ma [32];
    logic [31:0] mb [32];

    always #5 clk = ~clk;

    scr1_pipe_mprf_np_if #(.XLEN(32), .DEPTH(32), .NRD(2), .NWR(1)) ifa ();
    scr1_pipe_mprf_np_if #(.XLEN(32), .DEPTH(32), .NRD(2), .NWR(2)) ifb ();

    scr1_pipe_mprf_np #(.XLEN(32), .DEPTH(32), .NRD(2), .NWR(1), .READ_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .mprf_bus(ifa)
    );
    scr1_pipe_mprf_np #(.XLEN(32), .DEPTH(32), .NRD(2), .NWR(2), .READ_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .mprf_bus(ifb)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.exu2mprf_w_req_i   = '0;
        ifa.exu2mprf_rd_addr_i = '0;
        ifa.exu2mprf_rd_data_i = '0;
        ifa.exu2mprf_clr_req_i = 1'b0;
        ifb.exu2mprf_w_req_i   = '0;
        ifb.exu2mprf_rd_addr_i = '0;
        ifb.exu2mprf_rd_data_i = '0;
        ifb.exu2mprf_clr_req_i = 1'b0;
`ifdef SCR1_MPRF_PARITY_EN
        ifa.tb_par_flip_i = '0;
        ifb.tb_par_flip_i = '0;
`endif
    endtask

    task automatic clear_models();
        for (int k = 0; k < 32; k++) begin
            ma[k] = '0;
            mb[k] = '0;
        end
    endtask

    // Counts negedges with busy high; DEPTH=32 must give 31.
    task automatic count_busy(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (ifa.mprf2exu_busy_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 31) begin
            errors++;
            $display("FAIL %s: busy cycles got %0d expected 31", name, n);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        ifa.exu2mprf_rs_addr_i = '0;
        ifb.exu2mprf_rs_addr_i = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ifa.mprf2exu_busy_o !== 1'b1 || ifb.mprf2exu_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got a=%b b=%b expected 1", ifa.mprf2exu_busy_o, ifb.mprf2exu_busy_o);
        end
        checks++;
        if (ifb.mprf2exu_rs_data_o !== '0) begin
            errors++;
            $display("FAIL reset_rdata_b: got %h expected 0", ifb.mprf2exu_rs_data_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_busy("reset_sweep_len");
        checks++;
        if (ifb.mprf2exu_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_b_ready: busy got %b expected 0", ifb.mprf2exu_busy_o);
        end
        clear_models();
        for (int a = 1; a < 32; a++) begin
            ifa.exu2mprf_rs_addr_i[0] = 5'(a);
            ifa.exu2mprf_rs_addr_i[1] = 5'(32 - a);
            #1;
            checks++;
            if (ifa.mprf2exu_rs_data_o[0] !== ma[a] || ifa.mprf2exu_rs_data_o[1] !== ma[32 - a]) begin
                errors++;
                $display("FAIL post_sweep_zero x%0d: got %h %h expected 0", a,
                         ifa.mprf2exu_rs_data_o[0], ifa.mprf2exu_rs_data_o[1]);
            end
        end
    endtask

    task automatic test_async_write();
        cycle();
        ifa.exu2mprf_w_req_i      = 1'b1;
        ifa.exu2mprf_rd_addr_i[0] = 5'd5;
        ifa.exu2mprf_rd_data_i[0] = 32'hDEADBEEF;
        ifa.exu2mprf_rs_addr_i[0] = 5'd5;
        ifa.exu2mprf_rs_addr_i[1] = 5'd0;
        @(negedge clk);
        checks++;
        if (ifa.mprf2exu_rs_data_o[0] !== ma[5]) begin
            errors++;
            $display("FAIL async_same_cycle: got %h expected %h", ifa.mprf2exu_rs_data_o[0], ma[5]);
        end
        cycle();
        ma[5] = 32'hDEADBEEF;
        ifa.exu2mprf_w_req_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.mprf2exu_rs_data_o[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL async_next_cycle: got %h expected deadbeef", ifa.mprf2exu_rs_data_o[0]);
        end
        ifa.exu2mprf_w_req_i      = 1'b1;
        ifa.exu2mprf_rd_addr_i[0] = 5'd0;
        ifa.exu2mprf_rd_data_i[0] = 32'h12345678;
        cycle();
        ifa.exu2mprf_w_req_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.mprf2exu_rs_data_o[1] !== 32'h0) begin
            errors++;
            $display("FAIL x0_read: got %h expected 0", ifa.mprf2exu_rs_data_o[1]);
        end
    endtask

    task automatic test_write_priority();
        cycle();
        ifb.exu2mprf_w_req_i      = 2'b11;
        ifb.exu2mprf_rd_addr_i[0] = 5'd7;
        ifb.exu2mprf_rd_addr_i[1] = 5'd7;
        ifb.exu2mprf_rd_data_i[0] = 32'h11;
        ifb.exu2mprf_rd_data_i[1] = 32'h22;
        ifb.exu2mprf_rs_addr_i[0] = 5'd0;
        ifb.exu2mprf_rs_addr_i[1] = 5'd7;
        cycle();
        ifb.exu2mprf_w_req_i = '0;
        mb[7] = 32'h22;
        @(negedge clk);
        checks++;
        if (ifb.mprf2exu_rs_data_o[1] !== 32'h22 || ifb.mprf2exu_rs_data_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL prio_bypass: got %h %h expected 0 22", ifb.mprf2exu_rs_data_o[0],
                     ifb.mprf2exu_rs_data_o[1]);
        end
        cycle();
        @(negedge clk);
        checks++;
        if (ifb.mprf2exu_rs_data_o[1] !== 32'h22) begin
            errors++;
            $display("FAIL prio_stored: got %h expected 22", ifb.mprf2exu_rs_data_o[1]);
        end
    endtask

    task automatic test_random_async();
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra [2];
        logic [31:0] exp_v;
        cycle();
        repeat (200) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            ra[0] = 5'($urandom_range(0, 31));
            ra[1] = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ifa.exu2mprf_w_req_i      = we;
            ifa.exu2mprf_rd_addr_i[0] = wa;
            ifa.exu2mprf_rd_data_i[0] = wd;
            ifa.exu2mprf_rs_addr_i[0] = ra[0];
            ifa.exu2mprf_rs_addr_i[1] = ra[1];
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                exp_v = (ra[p] == 0) ? 32'h0 : ma[ra[p]];
                checks++;
                if (ifa.mprf2exu_rs_data_o[p] !== exp_v) begin
                    errors++;
                    $display("FAIL rand_async port%0d x%0d: got %h expected %h", p, ra[p],
                             ifa.mprf2exu_rs_data_o[p], exp_v);
                end
            end
            cycle();
            if (we && wa != 0) ma[wa] = wd;
        end
        idle_inputs();
    endtask

    task automatic test_random_registered();
        logic [1:0]  we;
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [4:0]  ra [2];
        logic [31:0] exp_v [2];
        @(negedge clk);
        repeat (200) begin
            we = 2'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++) begin
                wa[j] = 5'($urandom_range(0, 7));
                wd[j] = $urandom;
                ra[j] = 5'($urandom_range(0, 7));
                ifb.exu2mprf_rd_addr_i[j] = wa[j];
                ifb.exu2mprf_rd_data_i[j] = wd[j];
                ifb.exu2mprf_rs_addr_i[j] = ra[j];
            end
            ifb.exu2mprf_w_req_i = we;
            for (int j = 0; j < 2; j++)
                if (we[j] && wa[j] != 0) mb[wa[j]] = wd[j];
            for (int p = 0; p < 2; p++)
                exp_v[p] = (ra[p] == 0) ? 32'h0 : mb[ra[p]];
            cycle();
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (ifb.mprf2exu_rs_data_o[p] !== exp_v[p]) begin
                    errors++;
                    $display("FAIL rand_reg port%0d x%0d: got %h expected %h", p, ra[p],
                             ifb.mprf2exu_rs_data_o[p], exp_v[p]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int n;
        cycle();
        ifa.exu2mprf_w_req_i      = 1'b1;
        ifa.exu2mprf_rd_addr_i[0] = 5'd3;
        ifa.exu2mprf_rd_data_i[0] = 32'h55;
        ifa.exu2mprf_rs_addr_i[0] = 5'd3;
        ifa.exu2mprf_rs_addr_i[1] = 5'd20;
        cycle();
        ifa.exu2mprf_rd_addr_i[0] = 5'd20;
        ifa.exu2mprf_rd_data_i[0] = 32'hA5A5A5A5;
        cycle();
        ifa.exu2mprf_w_req_i = 1'b0;
        ma[3]  = 32'h55;
        ma[20] = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if (ifa.mprf2exu_rs_data_o[0] !== ma[3] || ifa.mprf2exu_rs_data_o[1] !== ma[20]) begin
            errors++;
            $display("FAIL clear_prefill: got %h %h expected %h %h", ifa.mprf2exu_rs_data_o[0],
                     ifa.mprf2exu_rs_data_o[1], ma[3], ma[20]);
        end
        ifa.exu2mprf_clr_req_i    = 1'b1;
        ifa.exu2mprf_w_req_i      = 1'b1;
        ifa.exu2mprf_rd_addr_i[0] = 5'd4;
        ifa.exu2mprf_rd_data_i[0] = 32'h44;
        cycle();
        ifa.exu2mprf_clr_req_i = 1'b0;
        ifa.exu2mprf_w_req_i   = 1'b0;
        n = 0;
        @(negedge clk);
        while (ifa.mprf2exu_busy_o === 1'b1 && n < 100) begin
            n++;
            if (n == 1) begin
                checks++;
                if (ifa.mprf2exu_rs_data_o[1] !== 32'h0) begin
                    errors++;
                    $display("FAIL busy_forces_zero: got %h expected 0", ifa.mprf2exu_rs_data_o[1]);
                end
            end
            if (n == 10) ifa.exu2mprf_clr_req_i = 1'b1;
            if (n == 11) ifa.exu2mprf_clr_req_i = 1'b0;
            if (n == 20) begin
                ifa.exu2mprf_w_req_i      = 1'b1;
                ifa.exu2mprf_rd_addr_i[0] = 5'd3;
                ifa.exu2mprf_rd_data_i[0] = 32'h99;
            end
            if (n == 21) ifa.exu2mprf_w_req_i = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (n !== 31) begin
            errors++;
            $display("FAIL clear_sweep_len: busy cycles got %0d expected 31", n);
        end
        clear_models();
        for (int k = 0; k < 32; k++) mb[k] = 32'h0;
        checks++;
        if (ifa.mprf2exu_rs_data_o[0] !== ma[3] || ifa.mprf2exu_rs_data_o[1] !== ma[20]) begin
            errors++;
            $display("FAIL clear_result: got x3=%h x20=%h expected 0 0", ifa.mprf2exu_rs_data_o[0],
                     ifa.mprf2exu_rs_data_o[1]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        ifa.exu2mprf_clr_req_i = 1'b1;
        cycle();
        ifa.exu2mprf_clr_req_i = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (ifa.mprf2exu_busy_o !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_busy: got %b expected 1", ifa.mprf2exu_busy_o);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_busy("mid_reset_sweep_len");
        clear_models();
        ifa.exu2mprf_rs_addr_i[0] = 5'd5;
        ifa.exu2mprf_rs_addr_i[1] = 5'd6;
        ifb.exu2mprf_rs_addr_i[0] = 5'd7;
        ifb.exu2mprf_rs_addr_i[1] = 5'd1;
        cycle();
        @(negedge clk);
        checks++;
        if (ifa.mprf2exu_rs_data_o !== {mb[6], ma[5]} || ifb.mprf2exu_rs_data_o !== {mb[1], mb[7]}) begin
            errors++;
            $display("FAIL mid_reset_zero: got a=%h b=%h expected 0", ifa.mprf2exu_rs_data_o,
                     ifb.mprf2exu_rs_data_o);
        end
    endtask

`ifdef SCR1_MPRF_PARITY_EN
    task automatic test_parity();
        cycle();
        ifa.exu2mprf_w_req_i      = 1'b1;
        ifa.exu2mprf_rd_addr_i[0] = 5'd9;
        ifa.exu2mprf_rd_data_i[0] = 32'h1;
        ifa.tb_par_flip_i         = 1'b1;
        ifa.exu2mprf_rs_addr_i[0] = 5'd9;
        cycle();
        ifa.exu2mprf_w_req_i = 1'b0;
        ifa.tb_par_flip_i    = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.mprf2exu_par_err_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL par_flag: got %b expected 1", ifa.mprf2exu_par_err_o[0]);
        end
        ifa.exu2mprf_w_req_i = 1'b1;
        cycle();
        ifa.exu2mprf_w_req_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.mprf2exu_par_err_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL par_clear: got %b expected 0", ifa.mprf2exu_par_err_o[0]);
        end
        ifb.exu2mprf_w_req_i      = 2'b01;
        ifb.exu2mprf_rd_addr_i[0] = 5'd9;
        ifb.exu2mprf_rd_data_i[0] = 32'h1;
        ifb.tb_par_flip_i         = 2'b01;
        ifb.exu2mprf_rs_addr_i[0] = 5'd9;
        cycle();
        ifb.exu2mprf_w_req_i = '0;
        ifb.tb_par_flip_i    = '0;
        @(negedge clk);
        checks++;
        if (ifb.mprf2exu_par_err_o[0] !== 1'b0 || ifb.mprf2exu_rs_data_o[0] !== 32'h1) begin
            errors++;
            $display("FAIL par_bypass: got err=%b data=%h expected 0 1", ifb.mprf2exu_par_err_o[0],
                     ifb.mprf2exu_rs_data_o[0]);
        end
        cycle();
        @(negedge clk);
        checks++;
        if (ifb.mprf2exu_par_err_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL par_reg_flag: got %b expected 1", ifb.mprf2exu_par_err_o[0]);
        end
    endtask
`endif

    initial begin
        clear_models();
        test_reset();
        test_async_write();
        test_write_priority();
        test_random_async();
        test_random_registered();
        test_clear();
        test_reset_mid_sweep();
`ifdef SCR1_MPRF_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
